// File: rtl/fighter_anim_seq.sv
// fighter_anim_seq
//   Per-player animation sequencer. It arbitrates move requests, steps through
//   animation frames on video-frame ticks and produces the gameplay timing flags.
// Ports:
//   vga_clk     sole clock
//   Reset       synchronous, active-high
//   frame_tick  one-cycle pulse per video frame
//   punch_req, kick_req, block_req  level requests
//   hurt_in     one-cycle pulse, player was hit
//   sprite_sel  0 idle, 1 punch, 2 kick, 3 block, 4 hurt
//   anim_step   frame index within the current move
//   hit_active  attack hitbox live (last step of punch/kick)
//   busy        not accepting new moves
//   move_done   one-cycle pulse when a punch/kick completes
module fighter_anim_seq #(
  parameter int HOLD_FRAMES = 6,
  parameter int PUNCH_STEPS = 3,
  parameter int KICK_STEPS  = 4,
  parameter int HURT_STEPS  = 2,
  parameter int COOLDOWN    = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       punch_req,
  input  logic       kick_req,
  input  logic       block_req,
  input  logic       hurt_in,
  output logic [2:0] sprite_sel,
  output logic [1:0] anim_step,
  output logic       hit_active,
  output logic       busy,
  output logic       move_done
);
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam int CW = $clog2(COOLDOWN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PUNCH, S_KICK, S_BLOCK, S_HURT, S_COOL
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      step_q, step_d;
  logic [CW-1:0]   cd_q, cd_d;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      anim_q, anim_d;
  logic            hit_q, hit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [2:0]      n_steps;
  logic [HW-1:0]   hold_inc;
  logic [2:0]      step_inc;
  logic [CW-1:0]   cd_inc;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    step_d   = step_q;
    cd_d     = cd_q;
    done_d   = 1'b0;
    hold_inc = hold_q + 1'b1;
    step_inc = {1'b0, step_q} + 3'd1;
    cd_inc   = cd_q + 1'b1;
    case (state_q)
      S_PUNCH: n_steps = 3'(PUNCH_STEPS);
      S_KICK:  n_steps = 3'(KICK_STEPS);
      default: n_steps = 3'(HURT_STEPS);
    endcase

    // hurt overrides everything, including coincident ticks and move ends
    if (hurt_in) begin
      state_d = S_HURT;
      hold_d  = '0;
      step_d  = '0;
      cd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_d = '0;
          step_d = '0;
          cd_d   = '0;
          if (kick_req)       state_d = S_KICK;
          else if (punch_req) state_d = S_PUNCH;
          else if (block_req) state_d = S_BLOCK;
        end
        S_PUNCH, S_KICK, S_HURT: begin
          if (frame_tick) begin
            if (hold_inc == HW'(HOLD_FRAMES)) begin
              hold_d = '0;
              if (step_inc == n_steps) begin
                step_d = '0;
                if (state_q == S_HURT) begin
                  state_d = S_IDLE;
                end else begin
                  state_d = S_COOL;
                  cd_d    = '0;
                  done_d  = 1'b1;
                end
              end else begin
                step_d = step_inc[1:0];
              end
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        S_COOL: begin
          if (frame_tick) begin
            if (cd_inc == CW'(COOLDOWN)) begin
              state_d = S_IDLE;
              cd_d    = '0;
            end else begin
              cd_d = cd_inc;
            end
          end
        end
        S_BLOCK: if (!block_req) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // outputs are decoded from the next state so they register with it
    case (state_d)
      S_PUNCH: sel_d = 3'd1;
      S_KICK:  sel_d = 3'd2;
      S_BLOCK: sel_d = 3'd3;
      S_HURT:  sel_d = 3'd4;
      default: sel_d = 3'd0;
    endcase
    anim_d = (state_d == S_PUNCH || state_d == S_KICK || state_d == S_HURT)
             ? step_d : 2'd0;
    hit_d  = (state_d == S_PUNCH && step_d == 2'(PUNCH_STEPS - 1)) ||
             (state_d == S_KICK  && step_d == 2'(KICK_STEPS - 1));
    busy_d = (state_d == S_PUNCH || state_d == S_KICK ||
              state_d == S_HURT  || state_d == S_COOL);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      step_q  <= '0;
      cd_q    <= '0;
      sel_q   <= '0;
      anim_q  <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      cd_q    <= cd_d;
      sel_q   <= sel_d;
      anim_q  <= anim_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sprite_sel = sel_q;
  assign anim_step  = anim_q;
  assign hit_active = hit_q;
  assign busy       = busy_q;
  assign move_done  = done_q;
endmodule
